// File: rtl/dtt_pkg.sv
// Shared types and sizing for the DTT frame scheduler.
// Provides the frame FSM state enum, window/index widths and a channel
// slice helper used by the channel bank.
package dtt_pkg;

   localparam int unsigned DTT_WIDTH  = 5;
   localparam int unsigned N_CH       = 8;
   localparam int unsigned WINDOW_LEN = (2 ** DTT_WIDTH) - 1;
   localparam int unsigned CH_IDX_W   = $clog2(N_CH);
   localparam int unsigned DATA_W     = N_CH * DTT_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Extract channel c's value from a packed frame word.
   function automatic logic [DTT_WIDTH-1:0] ch_val(input logic [DATA_W-1:0] d,
                                                    input int unsigned       c);
      return d[c*DTT_WIDTH +: DTT_WIDTH];
   endfunction

endpackage

// File: rtl/dtt_frame_ctrl_if.sv
// Frame handshake and spike/result bus of the DTT frame scheduler.
// master: frame source / result consumer.  slave: dtt_frame_ctrl.
//   in_valid, in_data, abort          : source -> controller
//   in_ready, spike_vec, spike_valid,
//   tick, frame_done, first_hit,
//   first_ch, first_time              : controller -> consumer
interface dtt_frame_ctrl_if;

   logic                                in_valid;
   logic                                in_ready;
   logic [dtt_pkg::DATA_W-1:0]          in_data;
   logic                                abort;
   logic [dtt_pkg::N_CH-1:0]            spike_vec;
   logic                                spike_valid;
   logic [dtt_pkg::DTT_WIDTH-1:0]       tick;
   logic                                frame_done;
   logic                                first_hit;
   logic [dtt_pkg::CH_IDX_W-1:0]        first_ch;
   logic [dtt_pkg::DTT_WIDTH-1:0]       first_time;

   modport master (
      output in_valid, in_data, abort,
      input  in_ready, spike_vec, spike_valid, tick, frame_done,
             first_hit, first_ch, first_time
   );

   modport slave (
      input  in_valid, in_data, abort,
      output in_ready, spike_vec, spike_valid, tick, frame_done,
             first_hit, first_ch, first_time
   );

endinterface

// File: rtl/dtt.sv
// Single delay-to-time encoder channel.
// Ports: CLK, nRES (sync, active-low), start (load value), value,
//        spike_c (high in the cycle value-1 cycles after the load edge).
// A value of 0 never spikes; each load spikes at most once.
module dtt
   import dtt_pkg::*;
(
   input  logic                 CLK,
   input  logic                 nRES,
   input  logic                 start,
   input  logic [DTT_WIDTH-1:0] value,
   output logic                 spike_c
);

   logic [DTT_WIDTH-1:0] cnt_q;

   // Down-counter parks at zero, so the ==1 decode fires exactly once.
   always_ff @(posedge CLK) begin
      if (!nRES) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DTT_WIDTH'(1);
      end
   end

   assign spike_c = (cnt_q == DTT_WIDTH'(1));

endmodule

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports: vec (request vector), idx_c (index of lowest set bit, 0 if none),
//        any_c (at least one bit set).
module lsb_prio_enc #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx_c = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec[i]) idx_c = IW'(i);
      end
   end

   assign any_c = |vec;

endmodule

// File: rtl/dtt_frame_ctrl.sv
// Frame scheduler for a bank of DTT spike encoders.
// Accepts one frame in IDLE, loads all channels in LOAD, runs a
// WINDOW_LEN-cycle RUN window exposing spikes with a tick stamp, then
// pulses frame_done in DONE and holds the earliest-spike winner.
// Ports: CLK, RES (sync, active-high), bus (dtt_frame_ctrl_if.slave).
module dtt_frame_ctrl
   import dtt_pkg::*;
(
   input  logic             CLK,
   input  logic             RES,
   dtt_frame_ctrl_if.slave  bus
);

   state_t                 state_q;
   state_t                 state_d;
   logic                   start;
   logic [DATA_W-1:0]      data_q;
   logic [DTT_WIDTH-1:0]   tick_q;
   logic                   first_hit_q;
   logic [CH_IDX_W-1:0]    first_ch_q;
   logic [DTT_WIDTH-1:0]   first_time_q;
   logic [N_CH-1:0]        raw_spk;
   logic [CH_IDX_W-1:0]    enc_idx;
   logic                   enc_any;
   logic                   run_last;
   logic                   abort_ok;

   assign run_last = (tick_q == DTT_WIDTH'(WINDOW_LEN - 1));
   assign abort_ok = bus.abort && ((state_q == LOAD) || (state_q == RUN));

   // State register.
   always_ff @(posedge CLK) begin
      if (RES) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and channel load strobe.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: if (bus.in_valid) state_d = LOAD;
         LOAD: begin
            start   = 1'b1;
            state_d = bus.abort ? IDLE : RUN;
         end
         RUN: begin
            if (bus.abort)    state_d = IDLE;
            else if (run_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Frame capture, tick counter and winner registers.
   always_ff @(posedge CLK) begin
      if (RES) begin
         data_q       <= '0;
         tick_q       <= '0;
         first_hit_q  <= 1'b0;
         first_ch_q   <= '0;
         first_time_q <= '0;
      end else begin
         if ((state_q == IDLE) && bus.in_valid) data_q <= bus.in_data;

         if ((state_q == RUN) && (state_d == RUN)) tick_q <= tick_q + DTT_WIDTH'(1);
         else                                      tick_q <= '0;

         // A new frame or an abort wipes the previous winner.
         if (((state_q == IDLE) && bus.in_valid) || abort_ok) begin
            first_hit_q  <= 1'b0;
            first_ch_q   <= '0;
            first_time_q <= '0;
         end else if ((state_q == RUN) && !first_hit_q && enc_any) begin
            first_hit_q  <= 1'b1;
            first_ch_q   <= enc_idx;
            first_time_q <= tick_q;
         end
      end
   end

   // Channel bank; LOAD overwrites every channel, so residue after abort is harmless.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      dtt u_dtt (
         .CLK     (CLK),
         .nRES    (~RES),
         .start   (start),
         .value   (ch_val(data_q, c)),
         .spike_c (raw_spk[c])
      );
   end

   lsb_prio_enc #(
      .N  (N_CH),
      .IW (CH_IDX_W)
   ) u_enc (
      .vec   (raw_spk),
      .idx_c (enc_idx),
      .any_c (enc_any)
   );

   // All outputs decode from registered state only.
   assign bus.in_ready    = (state_q == IDLE);
   assign bus.spike_valid = (state_q == RUN);
   assign bus.spike_vec   = (state_q == RUN) ? raw_spk : '0;
   assign bus.tick        = tick_q;
   assign bus.frame_done  = (state_q == DONE);
   assign bus.first_hit   = first_hit_q;
   assign bus.first_ch    = first_ch_q;
   assign bus.first_time  = first_time_q;

endmodule
